traffic_phase_monitor: RTL and testbench

Receive-side companion to the `traffic` controller. It samples a controller's car and walker lamp outputs, decodes them back into a phase, and tracks how long each phase dwells. It also checks that phases follow the legal order and reports safety or ordering violations. It sits beside each `traffic` instance in simulation and on-chip as a watchdog.

---
 rtl/traffic_phase_monitor.sv | 182 ++++++++++++++++++
 tb/tb_traffic_phase_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_monitor.sv
// Watchdog that decodes a traffic controller's lamp outputs back into phases, measures dwell and flags errors.
// Optional LONG_DWELL timeout is compiled in with `define TRAFFIC_MON_TIMEOUT_EN.
module traffic_phase_monitor #(
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 3,
    parameter int MAX_DWELL = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic [3:0]       i_car_traffic,
    input  logic [1:0]       i_walker_traffic,
    input  logic             i_err_clr,
    output logic [2:0]       o_phase,
    output logic [CNT_W-1:0] o_dwell,
    output logic [7:0]       o_cycle_cnt,
    output logic             o_err_valid,
    output logic [2:0]       o_err_code,
    output logic             o_err_sticky,
    output logic [2:0]       o_err_first
);

    typedef enum logic [2:0] {
        PH_UNSYNC  = 3'd0,
        PH_RED     = 3'd1,
        PH_GREEN   = 3'd2,
        PH_LEFT    = 3'd3,
        PH_YELLOW  = 3'd4,
        PH_ILLEGAL = 3'd7
    } phase_t;

    localparam logic [CNT_W-1:0] DWELL_SAT = '1;

    if (MAX_DWELL < MIN_DWELL) begin : g_bad_cfg
        $error("MAX_DWELL must not be below MIN_DWELL");
    end

    logic [3:0]       car_s1_reg;
    logic [1:0]       walk_s1_reg;
    logic             en_s1_reg;
    logic             clr_s1_reg;

    phase_t           phase_reg, phase_next;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic             exempt_reg, exempt_next;
    logic [7:0]       cycle_reg, cycle_next;
    logic             valid_reg;
    logic [2:0]       code_reg, code_next;
    logic             sticky_reg, sticky_next;
    logic [2:0]       first_reg, first_next;

    phase_t car_ph, new_ph;
    logic   walk_ok, walk_green, prev_legal, new_legal, changed;
    logic   err_ill, err_conf, err_order, err_short, err_long;

    function automatic logic order_ok(phase_t f, phase_t t);
        return (f == PH_RED    && t == PH_GREEN) ||
               (f == PH_GREEN  && (t == PH_LEFT || t == PH_YELLOW)) ||
               (f == PH_LEFT   && t == PH_YELLOW) ||
               (f == PH_YELLOW && t == PH_RED);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            car_s1_reg  <= '0;
            walk_s1_reg <= '0;
            en_s1_reg   <= 1'b0;
            clr_s1_reg  <= 1'b0;
        end else begin
            car_s1_reg  <= i_car_traffic;
            walk_s1_reg <= i_walker_traffic;
            en_s1_reg   <= i_enable;
            clr_s1_reg  <= i_err_clr;
        end
    end

    always_comb begin
        case (car_s1_reg)
            4'b1000: car_ph = PH_RED;
            4'b0001: car_ph = PH_GREEN;
            4'b0011: car_ph = PH_LEFT;
            4'b0100: car_ph = PH_YELLOW;
            default: car_ph = PH_ILLEGAL;
        endcase
    end

    assign walk_ok    = (walk_s1_reg == 2'b10) || (walk_s1_reg == 2'b01);
    assign walk_green = (walk_s1_reg == 2'b01);
    assign new_ph     = (car_ph == PH_ILLEGAL || !walk_ok) ? PH_ILLEGAL : car_ph;
    assign prev_legal = phase_reg inside {PH_RED, PH_GREEN, PH_LEFT, PH_YELLOW};
    assign new_legal  = new_ph inside {PH_RED, PH_GREEN, PH_LEFT, PH_YELLOW};
    assign changed    = (new_ph != phase_reg);

    // ILLEGAL only reports on entry; staying in ILLEGAL suppresses the pulse.
    assign err_ill   = (new_ph == PH_ILLEGAL) && (phase_reg != PH_ILLEGAL);
    assign err_conf  = new_legal && walk_green && (new_ph != PH_RED);
    assign err_order = changed && prev_legal && new_legal && !order_ok(phase_reg, new_ph);
    assign err_short = changed && prev_legal && !exempt_reg &&
                       (dwell_reg < CNT_W'(MIN_DWELL));

`ifdef TRAFFIC_MON_TIMEOUT_EN
    localparam bit LONG_REACHABLE = (MAX_DWELL < (2 ** CNT_W) - 1);
    // Fires on the edge that moves the counter to MAX_DWELL+1, so once per visit.
    assign err_long = LONG_REACHABLE && !changed && prev_legal &&
                      (dwell_reg == CNT_W'(MAX_DWELL));
`else
    assign err_long = 1'b0;
`endif

    always_comb begin
        phase_next  = phase_reg;
        dwell_next  = dwell_reg;
        exempt_next = exempt_reg;
        cycle_next  = cycle_reg;
        code_next   = 3'd0;
        sticky_next = sticky_reg;
        first_next  = first_reg;

        if (!en_s1_reg) begin
            phase_next  = PH_UNSYNC;
            dwell_next  = '0;
            exempt_next = 1'b0;
        end else begin
            phase_next = new_ph;
            if (changed) begin
                dwell_next  = {{(CNT_W-1){1'b0}}, 1'b1};
                // Phases entered from UNSYNC or ILLEGAL may be partial.
                exempt_next = !prev_legal;
            end else if (dwell_reg != DWELL_SAT) begin
                dwell_next = dwell_reg + 1'b1;
            end
            if (phase_reg == PH_RED && new_ph == PH_GREEN)
                cycle_next = cycle_reg + 8'd1;

            if (err_ill)        code_next = 3'd1;
            else if (err_conf)  code_next = 3'd2;
            else if (err_order) code_next = 3'd3;
            else if (err_short) code_next = 3'd4;
            else if (err_long)  code_next = 3'd5;
        end

        if (code_next != 3'd0) begin
            sticky_next = 1'b1;
            if (!sticky_reg || clr_s1_reg)
                first_next = code_next;
        end else if (clr_s1_reg) begin
            sticky_next = 1'b0;
            first_next  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg  <= PH_UNSYNC;
            dwell_reg  <= '0;
            exempt_reg <= 1'b0;
            cycle_reg  <= '0;
            valid_reg  <= 1'b0;
            code_reg   <= '0;
            sticky_reg <= 1'b0;
            first_reg  <= '0;
        end else begin
            phase_reg  <= phase_next;
            dwell_reg  <= dwell_next;
            exempt_reg <= exempt_next;
            cycle_reg  <= cycle_next;
            valid_reg  <= (code_next != 3'd0);
            code_reg   <= code_next;
            sticky_reg <= sticky_next;
            first_reg  <= first_next;
        end
    end

    assign o_phase      = phase_reg;
    assign o_dwell      = dwell_reg;
    assign o_cycle_cnt  = cycle_reg;
    assign o_err_valid  = valid_reg;
    assign o_err_code   = code_reg;
    assign o_err_sticky = sticky_reg;
    assign o_err_first  = first_reg;

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Directed bench for traffic_phase_monitor: nominal cycle, errors, priority, clear, enable and reset.
module tb_traffic_phase_monitor;

    localparam int CNT_W = 8;
    localparam logic [3:0] C_RED = 4'b1000, C_GREEN = 4'b0001, C_LEFT = 4'b0011, C_YELLOW = 4'b0100;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_enable = 1'b1;
    logic [3:0]       i_car_traffic = 4'b1000;
    logic [1:0]       i_walker_traffic = 2'b10;
    logic             i_err_clr = 1'b0;
    logic [2:0]       o_phase;
    logic [CNT_W-1:0] o_dwell;
    logic [7:0]       o_cycle_cnt;
    logic             o_err_valid;
    logic [2:0]       o_err_code;
    logic             o_err_sticky;
    logic [2:0]       o_err_first;

    int passed = 0;
    int total = 0;
    int err_seen = 0;
    int exp_cnt = 0;

    traffic_phase_monitor #(.CNT_W(CNT_W), .MIN_DWELL(3), .MAX_DWELL(20)) dut (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable),
        .i_car_traffic(i_car_traffic), .i_walker_traffic(i_walker_traffic),
        .i_err_clr(i_err_clr), .o_phase(o_phase), .o_dwell(o_dwell),
        .o_cycle_cnt(o_cycle_cnt), .o_err_valid(o_err_valid), .o_err_code(o_err_code),
        .o_err_sticky(o_err_sticky), .o_err_first(o_err_first)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (o_err_valid === 1'b1) err_seen++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset;
        #3;
        chk("rst_phase", o_phase, 0);
        chk("rst_dwell", o_dwell, 0);
        chk("rst_cycle", o_cycle_cnt, 0);
        chk("rst_valid", o_err_valid, 0);
        chk("rst_sticky", o_err_sticky, 0);
        chk("rst_first", o_err_first, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        $display("reset released, phase=%0d", o_phase);
    endtask

    task automatic test_nominal;
        logic [3:0] codes [4];
        int         ph [4];
        int         len [4];
        codes = '{C_RED, C_GREEN, C_LEFT, C_YELLOW};
        ph    = '{1, 2, 3, 4};
        len   = '{10, 10, 5, 4};
        err_seen = 0;
        for (int i = 0; i < 4; i++) begin
            i_car_traffic = codes[i];
            cyc(1);
            if (i == 0) begin
                chk("nom_latency", o_phase, 0);
            end else begin
                chk("nom_exit_phase", o_phase, ph[i-1]);
                chk("nom_exit_dwell", o_dwell, len[i-1]);
            end
            cyc(1);
            chk("nom_entry_phase", o_phase, ph[i]);
            chk("nom_entry_dwell", o_dwell, 1);
            $display("nominal: phase=%0d dwell=%0d", o_phase, o_dwell);
            cyc(len[i] - 2);
        end
        i_car_traffic = C_RED;
        cyc(1);
        chk("nom_yellow_dwell", o_dwell, 4);
        cyc(1);
        exp_cnt = 1;
        chk("nom_red_again", o_phase, 1);
        chk("nom_cycle_cnt", o_cycle_cnt, exp_cnt);
        cyc(3);
        chk("nom_no_errors", err_seen, 0);
    endtask

    task automatic test_conflict;
        i_car_traffic = C_GREEN;
        cyc(4);
        exp_cnt++;
        i_walker_traffic = 2'b01;
        cyc(1);
        i_walker_traffic = 2'b10;
        cyc(1);
        $display("conflict: valid=%0d code=%0d sticky=%0d first=%0d", o_err_valid, o_err_code, o_err_sticky, o_err_first);
        chk("conf_valid", o_err_valid, 1);
        chk("conf_code", o_err_code, 2);
        chk("conf_sticky", o_err_sticky, 1);
        chk("conf_first", o_err_first, 2);
        cyc(1);
        chk("conf_one_pulse", o_err_valid, 0);
        chk("conf_cycle_cnt", o_cycle_cnt, exp_cnt);
    endtask

    task automatic test_order_priority;
        i_car_traffic = C_RED;
        cyc(2);
        $display("order: valid=%0d code=%0d phase=%0d", o_err_valid, o_err_code, o_phase);
        chk("order_code", o_err_code, 3);
        chk("order_phase", o_phase, 1);
        chk("order_first_held", o_err_first, 2);
        i_car_traffic = 4'b0110;
        i_walker_traffic = 2'b01;
        cyc(2);
        $display("illegal: valid=%0d code=%0d phase=%0d", o_err_valid, o_err_code, o_phase);
        chk("ill_valid", o_err_valid, 1);
        chk("ill_code", o_err_code, 1);
        chk("ill_phase", o_phase, 7);
        err_seen = 0;
        cyc(3);
        chk("ill_no_repeat", err_seen, 0);
        i_car_traffic = C_RED;
        i_walker_traffic = 2'b10;
        cyc(2);
        chk("ill_exit_phase", o_phase, 1);
        chk("ill_exit_no_err", o_err_valid, 0);
    endtask

    task automatic test_short_dwell_clear;
        cyc(3);
        i_car_traffic = C_GREEN;
        cyc(4);
        exp_cnt++;
        i_car_traffic = C_YELLOW;
        cyc(2);
        i_car_traffic = C_RED;
        cyc(2);
        $display("short: valid=%0d code=%0d phase=%0d", o_err_valid, o_err_code, o_phase);
        chk("short_valid", o_err_valid, 1);
        chk("short_code", o_err_code, 4);
        cyc(3);
        i_err_clr = 1'b1;
        cyc(1);
        i_err_clr = 1'b0;
        cyc(1);
        chk("clr_sticky", o_err_sticky, 0);
        chk("clr_first", o_err_first, 0);
        i_car_traffic = C_GREEN;
        cyc(4);
        exp_cnt++;
        i_err_clr = 1'b1;
        i_walker_traffic = 2'b01;
        cyc(1);
        i_err_clr = 1'b0;
        i_walker_traffic = 2'b10;
        cyc(1);
        $display("clr+err: sticky=%0d first=%0d", o_err_sticky, o_err_first);
        chk("clr_err_sticky", o_err_sticky, 1);
        chk("clr_err_first", o_err_first, 2);
    endtask

    task automatic test_enable;
        i_car_traffic = C_LEFT;
        cyc(4);
        err_seen = 0;
        i_enable = 1'b0;
        cyc(2);
        $display("disable: phase=%0d dwell=%0d cycles=%0d", o_phase, o_dwell, o_cycle_cnt);
        chk("dis_phase", o_phase, 0);
        chk("dis_dwell", o_dwell, 0);
        chk("dis_cycle_hold", o_cycle_cnt, exp_cnt);
        chk("dis_sticky_hold", o_err_sticky, 1);
        i_enable = 1'b1;
        i_car_traffic = C_YELLOW;
        cyc(1);
        i_car_traffic = C_RED;
        cyc(4);
        chk("reen_no_err", err_seen, 0);
        chk("reen_phase", o_phase, 1);
    endtask

    task automatic test_async_reset;
        cyc(2);
        #3;
        reset_n = 1'b0;
        #1;
        $display("async reset: phase=%0d dwell=%0d cycles=%0d", o_phase, o_dwell, o_cycle_cnt);
        chk("ares_phase", o_phase, 0);
        chk("ares_dwell", o_dwell, 0);
        chk("ares_cycle", o_cycle_cnt, 0);
        chk("ares_sticky", o_err_sticky, 0);
        chk("ares_first", o_err_first, 0);
        chk("ares_code", o_err_code, 0);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_long_hold;
        int pulses = 0;
        int dwell_at = 0;
        int code_at = 0;
        int exp_pulses;
`ifdef TRAFFIC_MON_TIMEOUT_EN
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        i_car_traffic = C_RED;
        cyc(5);
        i_car_traffic = C_GREEN;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (o_err_valid === 1'b1) begin
                pulses++;
                dwell_at = o_dwell;
                code_at = o_err_code;
            end
        end
        $display("long hold: pulses=%0d dwell_at=%0d code_at=%0d dwell=%0d", pulses, dwell_at, code_at, o_dwell);
        chk("long_pulses", pulses, exp_pulses);
`ifdef TRAFFIC_MON_TIMEOUT_EN
        chk("long_dwell_at", dwell_at, 21);
        chk("long_code", code_at, 5);
`endif
        chk("dwell_saturate", o_dwell, 255);
        chk("long_cycle_cnt", o_cycle_cnt, 1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_conflict();
        test_order_priority();
        test_short_dwell_clear();
        test_enable();
        test_async_reset();
        test_long_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
